acorn_ad_sequencer: RTL and testbench

- Parametrised, handshaked generator of the per-step (m, ca, cb) bit stream that drives the ACORN-128 state update, one step per accepted beat.
- Covers both the associated-data phase and the plaintext phase, selected by `mode`, with a runtime data length up to MAX_LEN bits.
- Sits between the bit-serial data source and the state-update core.
- Replaces the fixed 128-bit AD sequencing with variable length, a mode select, back-pressure and completion/error signalling.

---
 rtl/acorn_ad_sequencer.sv | 165 ++++++++++++++++
 tb/tb_acorn_ad_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/acorn_ad_sequencer.sv
// ACORN-128 step sequencer: turns a bit-serial AD/plaintext stream
// into per-step (m, ca, cb) beats with padding and ready/valid flow.
module acorn_ad_sequencer #(
  parameter int MAX_LEN  = 1024,
  parameter int LEN_W    = 11,
  parameter int CA_TAIL  = 128,
  parameter int PAD_ZERO = 255,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             mode,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             m_bit,
  output logic             ca_bit,
  output logic             cb_bit,
  output logic             step_valid,
  input  logic             step_ready,
  output logic [CNT_W-1:0] step_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD1,
    ZERO,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] idx, idx_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic             mode_q, mode_n;
  logic             m_n, ca_n, cb_n;
  logic             sv_n;
  logic [CNT_W-1:0] step_idx_n;
  logic             busy_n, done_n, err_n;

  logic             load;
  logic             len_ok;
  logic [CNT_W-1:0] len_x;
  logic [CNT_W-1:0] last_data;
  logic [CNT_W-1:0] ca_end;
  logic [CNT_W-1:0] last_step;

  assign load      = !step_valid | step_ready;
  assign len_ok    = len <= LEN_W'(MAX_LEN);
  assign len_x     = {{(CNT_W-LEN_W){1'b0}}, len_q};
  assign last_data = len_x - CNT_W'(1);
  assign ca_end    = len_x + CNT_W'(CA_TAIL);
  assign last_step = len_x + CNT_W'(PAD_ZERO);
  assign din_ready = (state == DATA) & load;

  // State, counters, latched request and the single output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      m_bit      <= 1'b0;
      ca_bit     <= 1'b0;
      cb_bit     <= 1'b0;
      step_valid <= 1'b0;
      step_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      len_q      <= len_n;
      mode_q     <= mode_n;
      m_bit      <= m_n;
      ca_bit     <= ca_n;
      cb_bit     <= cb_n;
      step_valid <= sv_n;
      step_idx   <= step_idx_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

  // Next state and next step; a consumed step is dropped unless refilled
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    len_n      = len_q;
    mode_n     = mode_q;
    m_n        = m_bit;
    ca_n       = ca_bit;
    cb_n       = cb_bit;
    sv_n       = step_valid & ~step_ready;
    step_idx_n = step_idx;
    busy_n     = busy;
    done_n     = 1'b0;
    err_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_n   = len;
            mode_n  = mode;
            busy_n  = 1'b1;
            idx_n   = '0;
            state_n = (len != '0) ? DATA : PAD1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      DATA: begin
        if (load && din_valid) begin
          m_n        = din;
          ca_n       = 1'b1;
          cb_n       = ~mode_q;
          sv_n       = 1'b1;
          step_idx_n = idx;
          idx_n      = idx + CNT_W'(1);
          if (idx == last_data) state_n = PAD1;
        end
      end
      PAD1: begin
        if (load) begin
          m_n        = 1'b1;
          ca_n       = idx < ca_end;
          cb_n       = ~mode_q;
          sv_n       = 1'b1;
          step_idx_n = idx;
          idx_n      = idx + CNT_W'(1);
          state_n    = (idx == last_step) ? DRAIN : ZERO;
        end
      end
      ZERO: begin
        if (load) begin
          m_n        = 1'b0;
          ca_n       = idx < ca_end;
          cb_n       = ~mode_q;
          sv_n       = 1'b1;
          step_idx_n = idx;
          idx_n      = idx + CNT_W'(1);
          if (idx == last_step) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (step_valid && step_ready) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_acorn_ad_sequencer.sv
// Directed bench for acorn_ad_sequencer: step stream model,
// stall stability, error pulse, abort and restart.
module tb_acorn_ad_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] len = '0;
  logic        mode = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        m_bit, ca_bit, cb_bit;
  logic        step_valid;
  logic        step_ready = 1'b0;
  logic [11:0] step_idx;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  logic data [0:1023];

  always #5 clk = ~clk;

  acorn_ad_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .m_bit(m_bit), .ca_bit(ca_bit), .cb_bit(cb_bit),
    .step_valid(step_valid), .step_ready(step_ready),
    .step_idx(step_idx), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {23'b0, din_ready, m_bit, ca_bit, cb_bit, step_valid,
            busy, done, err, |step_idx};
  endfunction

  task automatic run_seq(input int l, input bit md, input bit stall,
                         input bit gap, input int abort_at,
                         input int inject_at, input string tag);
    int k = 0;
    int ptr = 0;
    int cyc = 0;
    int dones = 0;
    int done_k = -1;
    int drdy = 0;
    int post = 0;
    bit fin = 0;
    bit aborted = 0;
    bit hold_v = 0;
    logic [31:0] hold = '0;
    logic [31:0] cur;
    logic [31:0] e;
    logic em;
    for (int i = 0; i < 1024; i++) data[i] = 1'($urandom);
    @(negedge clk);
    start = 1'b1;
    len = 11'(l);
    mode = md;
    din_valid = 1'b0;
    step_ready = 1'b0;
    while (!fin && !aborted && cyc < 3000) begin
      @(negedge clk);
      start = (cyc == inject_at);
      len = (cyc == inject_at) ? 11'd3 : 11'(l);
      mode = (cyc == inject_at) ? ~md : md;
      step_ready = stall ? cyc[0] : 1'b1;
      din_valid = gap ? ((cyc % 3) != 2) : 1'b1;
      din = (ptr < 1024) ? data[ptr] : 1'b0;
      #1;
      cur = {17'b0, step_idx, m_bit, ca_bit, cb_bit};
      if (cyc == 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (hold_v) chk({tag, "_hold"}, {31'b0, step_valid} | (cur << 1),
                      32'd1 | (hold << 1));
      hold_v = step_valid && !step_ready;
      hold = cur;
      if (step_valid && step_ready) begin
        em = (k < l) ? data[k] : (k == l);
        e = {17'b0, 12'(k), em, 1'(k < l + 128), ~md};
        chk({tag, "_step"}, cur, e);
        k++;
        if (abort_at >= 0 && k - 1 == abort_at) begin
          rst = 1'b0;
          #1;
          chk({tag, "_rst_outs"}, outs(), 32'd0);
          aborted = 1;
        end
      end
      if (din_valid && din_ready) ptr++;
      if (din_ready) drdy++;
      if (done) begin
        dones++;
        done_k = k;
      end
      if (dones > 0) post++;
      if (post > 3) fin = 1;
      cyc++;
    end
    start = 1'b0;
    din_valid = 1'b0;
    if (aborted) begin
      @(negedge clk);
      chk({tag, "_rst_hold"}, outs(), 32'd0);
      chk({tag, "_no_done"}, 32'(dones), 32'd0);
      rst = 1'b1;
    end else begin
      chk({tag, "_finished"}, 32'(fin), 32'd1);
      chk({tag, "_nsteps"}, 32'(k), 32'(l + 256));
      chk({tag, "_ndone"}, 32'(dones), 32'd1);
      chk({tag, "_done_at"}, 32'(done_k), 32'(l + 256));
      chk({tag, "_nbits"}, 32'(ptr), 32'(l));
      chk({tag, "_idle"}, {30'b0, busy, step_valid}, 32'd0);
      if (l == 0) chk({tag, "_no_drdy"}, 32'(drdy), 32'd0);
    end
  endtask

  initial begin
    #2;
    chk("reset_outs", outs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs(), 32'd0);

    run_seq(128, 1'b0, 1'b0, 1'b0, -1, -1, "ad128");
    run_seq(0, 1'b1, 1'b0, 1'b0, -1, -1, "msg0");
    run_seq(5, 1'b0, 1'b1, 1'b1, -1, -1, "stall5");

    @(negedge clk);
    start = 1'b1;
    len = 11'd1025;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", {30'b0, busy, step_valid}, 32'd0);
    @(negedge clk);
    chk("err_clear", {29'b0, err, busy, step_valid}, 32'd0);

    run_seq(64, 1'b0, 1'b0, 1'b0, 50, -1, "abort64");
    run_seq(64, 1'b0, 1'b0, 1'b0, -1, -1, "rerun64");
    run_seq(20, 1'b1, 1'b1, 1'b0, -1, 20, "inject20");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
